rand_sample_reader: RTL and testbench

- Consumer end of the entropy chain: reads the free-running `state` word from the LHCA generator every clock and runs online health tests (repetition count and adaptive proportion) on the raw samples.
- Discards a startup block of samples, then packs consecutive samples into wide output words delivered over a valid/ready handshake.
- On any health-test failure it raises a sticky `alarm` and stops emitting data until reset.

---
 rtl/rand_pkg.sv | 15 +
 rtl/rand_health_test.sv | 64 ++++++
 rtl/rand_sample_reader.sv | 102 ++++++++++
 tb/tb_rand_sample_reader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and helpers for the random sample reader and its health tests.
package rand_pkg;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        FAILED  = 2'd2
    } fsm_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rand_health_test.sv
// Online repetition-count and adaptive-proportion tests on raw samples.
// fail is combinational on the current sample; the parent registers it.
module rand_health_test
    import rand_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int RCT_CUTOFF = 8,
    parameter int APT_WINDOW = 64,
    parameter int APT_CUTOFF = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample,
    output logic             fail
);

    localparam int RW = cnt_w(RCT_CUTOFF);
    localparam int AW = cnt_w(APT_CUTOFF);
    localparam int PW = cnt_w(APT_WINDOW - 1);

    logic [WIDTH-1:0] prev_sample;
    logic [WIDTH-1:0] ref_sample;
    logic [RW-1:0]    rct_cnt;
    logic [RW-1:0]    rct_next;
    logic [AW-1:0]    apt_cnt;
    logic [AW-1:0]    apt_next;
    logic [PW-1:0]    apt_pos;

    // rct_cnt == 0 only before the first sample, so it doubles as "no previous".
    always_comb begin
        rct_next = RW'(1);
        if (rct_cnt != '0 && sample == prev_sample)
            rct_next = (rct_cnt == RW'(RCT_CUTOFF)) ? rct_cnt : rct_cnt + RW'(1);

        apt_next = AW'(1);
        if (apt_pos != '0) begin
            if (sample == ref_sample)
                apt_next = (apt_cnt == AW'(APT_CUTOFF)) ? apt_cnt : apt_cnt + AW'(1);
            else
                apt_next = apt_cnt;
        end

        fail = enable && ((rct_next >= RW'(RCT_CUTOFF)) || (apt_next >= AW'(APT_CUTOFF)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sample <= '0;
            ref_sample  <= '0;
            rct_cnt     <= '0;
            apt_cnt     <= '0;
            apt_pos     <= '0;
        end else if (enable) begin
            prev_sample <= sample;
            rct_cnt     <= rct_next;
            apt_cnt     <= apt_next;
            if (apt_pos == '0)
                ref_sample <= sample;
            apt_pos <= (apt_pos == PW'(APT_WINDOW - 1)) ? '0 : apt_pos + PW'(1);
        end
    end

endmodule

// File: rtl/rand_sample_reader.sv
// Reads generator samples, discards a startup block, packs words for a
// valid/ready consumer and latches a sticky alarm on any health-test trip.
//   state   | meaning
//   STARTUP | discarding the first STARTUP_SAMPLES samples
//   RUN     | packing samples into output words
//   FAILED  | health test tripped; output frozen until reset
module rand_sample_reader
    import rand_pkg::*;
#(
    parameter int WIDTH           = 12,
    parameter int WORDS           = 2,
    parameter int STARTUP_SAMPLES = 64,
    parameter int RCT_CUTOFF      = 8,
    parameter int APT_WINDOW      = 64,
    parameter int APT_CUTOFF      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       state,
    output logic [WIDTH*WORDS-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   alarm,
    output logic                   running
);

    localparam int OUT_WIDTH = WIDTH * WORDS;
    localparam int SW        = cnt_w(STARTUP_SAMPLES - 1);
    localparam int KW        = cnt_w(WORDS - 1);

    fsm_t                 fsm;
    logic [SW-1:0]        startup_cnt;
    logic [KW-1:0]        word_idx;
    logic [OUT_WIDTH-1:0] pack_buf;
    logic [OUT_WIDTH-1:0] word_next;
    logic                 trip;

    rand_health_test #(
        .WIDTH      (WIDTH),
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk    (clk),
        .reset  (reset),
        .enable (fsm != FAILED),
        .sample (state),
        .fail   (trip)
    );

    always_comb begin
        word_next = pack_buf;
        word_next[word_idx*WIDTH +: WIDTH] = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= STARTUP;
            startup_cnt <= '0;
            word_idx    <= '0;
            pack_buf    <= '0;
            data        <= '0;
            valid       <= 1'b0;
            alarm       <= 1'b0;
            running     <= 1'b0;
        end else if (fsm != FAILED && trip) begin
            // A trip beats a same-edge transfer: the pending word is dropped.
            fsm      <= FAILED;
            alarm    <= 1'b1;
            valid    <= 1'b0;
            running  <= 1'b0;
            word_idx <= '0;
            pack_buf <= '0;
        end else begin
            case (fsm)
                STARTUP: begin
                    if (startup_cnt == SW'(STARTUP_SAMPLES - 1)) begin
                        fsm     <= RUN;
                        running <= 1'b1;
                    end else begin
                        startup_cnt <= startup_cnt + SW'(1);
                    end
                end
                RUN: begin
                    if (valid) begin
                        if (ready)
                            valid <= 1'b0;
                    end else if (word_idx == KW'(WORDS - 1)) begin
                        data     <= word_next;
                        valid    <= 1'b1;
                        word_idx <= '0;
                    end else begin
                        pack_buf <= word_next;
                        word_idx <= word_idx + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_sample_reader.sv
// Directed bench for rand_sample_reader with hand-computed expectations.
module tb_rand_sample_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] state = '0;
    logic [23:0] data;
    logic        valid;
    logic        ready = 1'b0;
    logic        alarm;
    logic        running;

    int checks = 0;
    int failures = 0;

    rand_sample_reader dut (
        .clk     (clk),
        .reset   (reset),
        .state   (state),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .alarm   (alarm),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        state = 12'h0;
        ready = 1'b0;
        do_reset(3);
        checks++; if (data !== 24'h0)  begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (alarm !== 1'b0)  begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    endtask

    task automatic test_incrementing();
        logic exp_valid;
        logic [23:0] exp_data;
        do_reset(3);
        ready = 1'b1;
        for (int n = 0; n <= 68; n++) begin
            state = 12'(n);
            step();
            exp_valid = (n == 65) || (n == 68);
            checks++; if (valid !== exp_valid) begin failures++; $display("FAIL inc_valid n=%0d got=%b exp=%b", n, valid, exp_valid); end
            checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL inc_alarm n=%0d got=%b exp=0", n, alarm); end
            if (n == 65 || n == 68) begin
                exp_data = {12'(n), 12'(n - 1)};
                checks++; if (data !== exp_data) begin failures++; $display("FAIL inc_data n=%0d got=%h exp=%h", n, data, exp_data); end
            end
            if (n == 62) begin
                checks++; if (running !== 1'b0) begin failures++; $display("FAIL inc_running_early got=%b exp=0", running); end
            end
            if (n == 63) begin
                checks++; if (running !== 1'b1) begin failures++; $display("FAIL inc_running got=%b exp=1", running); end
            end
        end
    endtask

    task automatic test_rct();
        logic exp_alarm;
        do_reset(3);
        ready = 1'b1;
        state = 12'h5A5;
        for (int n = 0; n <= 15; n++) begin
            step();
            exp_alarm = (n >= 7);
            checks++; if (alarm !== exp_alarm) begin failures++; $display("FAIL rct_alarm n=%0d got=%b exp=%b", n, alarm, exp_alarm); end
            checks++; if (valid !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL rct_outputs n=%0d valid=%b running=%b exp=0,0", n, valid, running); end
        end
    endtask

    task automatic test_apt();
        logic exp_alarm;
        do_reset(3);
        ready = 1'b1;
        for (int n = 0; n <= 63; n++) begin
            state = (n % 4 == 0) ? 12'h0AA : 12'(12'h100 + n);
            step();
            exp_alarm = (n >= 60);
            checks++; if (alarm !== exp_alarm) begin failures++; $display("FAIL apt_alarm n=%0d got=%b exp=%b", n, alarm, exp_alarm); end
            checks++; if (valid !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL apt_outputs n=%0d valid=%b running=%b exp=0,0", n, valid, running); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(3);
        for (int n = 0; n <= 77; n++) begin
            ready = (n >= 75);
            state = 12'(n);
            step();
            if (n >= 65 && n <= 74) begin
                checks++; if (valid !== 1'b1 || data !== {12'd65, 12'd64}) begin failures++; $display("FAIL bp_hold n=%0d valid=%b data=%h exp=1,041040", n, valid, data); end
            end
            if (n == 75 || n == 76) begin
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_gap n=%0d got=%b exp=0", n, valid); end
            end
            if (n == 77) begin
                checks++; if (valid !== 1'b1 || data !== {12'd77, 12'd76}) begin failures++; $display("FAIL bp_next valid=%b data=%h exp=1,04d04c", valid, data); end
            end
        end
    endtask

    task automatic test_trip_pending();
        do_reset(3);
        for (int n = 0; n <= 73; n++) begin
            state = (n <= 65) ? 12'(n) : 12'h777;
            ready = (n == 73);
            step();
            if (n >= 65 && n <= 72) begin
                checks++; if (valid !== 1'b1 || alarm !== 1'b0) begin failures++; $display("FAIL trip_pending n=%0d valid=%b alarm=%b exp=1,0", n, valid, alarm); end
            end
        end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL trip_valid got=%b exp=0", valid); end
        checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL trip_alarm got=%b exp=1", alarm); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL trip_running got=%b exp=0", running); end
        state = 12'h123;
        ready = 1'b1;
        repeat (5) step();
        checks++; if (valid !== 1'b0 || alarm !== 1'b1) begin failures++; $display("FAIL trip_sticky valid=%b alarm=%b exp=0,1", valid, alarm); end
    endtask

    task automatic test_reset_from_failed();
        int first_valid;
        do_reset(1);
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL rf_alarm got=%b exp=0", alarm); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL rf_running got=%b exp=0", running); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rf_valid got=%b exp=0", valid); end
        ready = 1'b1;
        first_valid = -1;
        for (int n = 0; n <= 70; n++) begin
            state = 12'(n + 1000);
            step();
            if (valid === 1'b1 && first_valid < 0)
                first_valid = n;
        end
        checks++; if (first_valid != 65) begin failures++; $display("FAIL rf_first_valid got=%0d exp=65", first_valid); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL rf_alarm_after got=%b exp=0", alarm); end
    endtask

    initial begin
        test_reset();
        test_incrementing();
        test_rct();
        test_apt();
        test_backpressure();
        test_trip_pending();
        test_reset_from_failed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
